// File: rtl/gpio_v2_pkg.sv
// Shared register map for the APB GPIO block: byte offsets, register index enum
// and the offset decoder used by the top level.
package gpio_v2_pkg;

   localparam logic [7:0] OFF_DATA_IN   = 8'h00;
   localparam logic [7:0] OFF_DATA_OUT  = 8'h04;
   localparam logic [7:0] OFF_OUT_SET   = 8'h08;
   localparam logic [7:0] OFF_OUT_CLR   = 8'h0C;
   localparam logic [7:0] OFF_OUT_TGL   = 8'h10;
   localparam logic [7:0] OFF_OE        = 8'h14;
   localparam logic [7:0] OFF_INTR_EN   = 8'h18;
   localparam logic [7:0] OFF_INTR_POS  = 8'h1C;
   localparam logic [7:0] OFF_INTR_NEG  = 8'h20;
   localparam logic [7:0] OFF_INTR_LVL  = 8'h24;
   localparam logic [7:0] OFF_INTR_STAT = 8'h28;
   localparam logic [7:0] OFF_FILT_EN   = 8'h2C;
   localparam logic [7:0] OFF_FILT_CNT  = 8'h30;

   typedef enum logic [3:0] {
      REG_DATA_IN,
      REG_DATA_OUT,
      REG_OUT_SET,
      REG_OUT_CLR,
      REG_OUT_TGL,
      REG_OE,
      REG_INTR_EN,
      REG_INTR_POS,
      REG_INTR_NEG,
      REG_INTR_LVL,
      REG_INTR_STAT,
      REG_FILT_EN,
      REG_FILT_CNT,
      REG_NONE
   } regIdx_e;

   function automatic regIdx_e decodeOffset(input logic [7:0] off);
      case (off)
         OFF_DATA_IN:   return REG_DATA_IN;
         OFF_DATA_OUT:  return REG_DATA_OUT;
         OFF_OUT_SET:   return REG_OUT_SET;
         OFF_OUT_CLR:   return REG_OUT_CLR;
         OFF_OUT_TGL:   return REG_OUT_TGL;
         OFF_OE:        return REG_OE;
         OFF_INTR_EN:   return REG_INTR_EN;
         OFF_INTR_POS:  return REG_INTR_POS;
         OFF_INTR_NEG:  return REG_INTR_NEG;
         OFF_INTR_LVL:  return REG_INTR_LVL;
         OFF_INTR_STAT: return REG_INTR_STAT;
         OFF_FILT_EN:   return REG_FILT_EN;
         OFF_FILT_CNT:  return REG_FILT_CNT;
         default:       return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input path: 2-flop synchronizer followed by a glitch filter that only
// accepts a new level once it has persisted longer than the programmed threshold.
module gpio_pin_filter #(
   parameter int FILT_W = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              pin_i,
   input  logic              filt_en_i,
   input  logic [FILT_W-1:0] filt_cnt_i,
   output logic              filt_o
);

   logic              sync1Q, syncQ;
   logic              filtQ, filtD;
   logic [FILT_W-1:0] cntQ, cntD;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1Q <= 1'b0;
         syncQ  <= 1'b0;
         filtQ  <= 1'b0;
         cntQ   <= '0;
      end else begin
         sync1Q <= pin_i;
         syncQ  <= sync1Q;
         filtQ  <= filtD;
         cntQ   <= cntD;
      end
   end

   // Threshold and enable are sampled live, so reprogramming affects a running count
   always_comb begin
      filtD = filtQ;
      cntD  = cntQ;
      if (!filt_en_i) begin
         filtD = syncQ;
         cntD  = '0;
      end else if (syncQ != filtQ) begin
         if (cntQ >= filt_cnt_i) begin
            filtD = syncQ;
            cntD  = '0;
         end else if (cntQ != '1) begin
            cntD = cntQ + FILT_W'(1);
         end
      end else begin
         cntD = '0;
      end
   end

   assign filt_o = filtQ;

endmodule

// File: rtl/gpio_v2.sv
// APB GPIO controller: register file, set/clear/toggle output access, filtered
// inputs and sticky edge/level interrupts.
import gpio_v2_pkg::*;

module gpio_v2 #(
   parameter int NUM_PINS = 32,
   parameter int FILT_W   = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [31:0]         PADDR,
   input  logic [31:0]         PWDATA,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   input  logic [NUM_PINS-1:0] gpio_in,
   output logic [NUM_PINS-1:0] gpio_out,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                interrupt
);

   typedef logic [NUM_PINS-1:0] pinVec_t;

   pinVec_t dataOutQ, dataOutD, oeQ, oeD;
   pinVec_t intrEnQ, intrEnD, intrPosQ, intrPosD, intrNegQ, intrNegD;
   pinVec_t intrLvlQ, intrLvlD, intrStatQ, intrStatD, filtEnQ, filtEnD;
   pinVec_t filtVec, filtDlyQ, posEdge, negEdge, intrEvt, w1c, wdata;
   logic [FILT_W-1:0] filtCntQ, filtCntD;

   regIdx_e     regSel;
   logic        access, errAcc, wrOk;
   logic [31:0] rdVal;
   logic        unusedAddr;

   for (genvar i = 0; i < NUM_PINS; i++) begin : gPin
      gpio_pin_filter #(.FILT_W(FILT_W)) uFilt (
         .clk        (clk),
         .n_rst      (n_rst),
         .pin_i      (gpio_in[i]),
         .filt_en_i  (filtEnQ[i]),
         .filt_cnt_i (filtCntQ),
         .filt_o     (filtVec[i])
      );
   end

   assign unusedAddr = ^PADDR[31:8];
   assign regSel     = decodeOffset(PADDR[7:0]);
   assign access     = PSEL & PENABLE;
   assign wdata      = PWDATA[NUM_PINS-1:0];
   assign PREADY     = 1'b1;

   always_comb begin
      rdVal  = '0;
      errAcc = 1'b0;
      case (regSel)
         REG_DATA_IN:   begin rdVal = 32'(filtVec); errAcc = PWRITE; end
         REG_DATA_OUT:  rdVal = 32'(dataOutQ);
         REG_OUT_SET,
         REG_OUT_CLR,
         REG_OUT_TGL:   errAcc = ~PWRITE;
         REG_OE:        rdVal = 32'(oeQ);
         REG_INTR_EN:   rdVal = 32'(intrEnQ);
         REG_INTR_POS:  rdVal = 32'(intrPosQ);
         REG_INTR_NEG:  rdVal = 32'(intrNegQ);
         REG_INTR_LVL:  rdVal = 32'(intrLvlQ);
         REG_INTR_STAT: rdVal = 32'(intrStatQ);
         REG_FILT_EN:   rdVal = 32'(filtEnQ);
         REG_FILT_CNT:  rdVal = 32'(filtCntQ);
         default:       errAcc = 1'b1;
      endcase
   end

   // Response outputs are forced quiet while reset is asserted
   assign PRDATA  = (n_rst && access && !PWRITE && !errAcc) ? rdVal : '0;
   assign PSLVERR = n_rst && access && errAcc;
   assign wrOk    = access & PWRITE & ~errAcc;

   assign posEdge = filtVec & ~filtDlyQ;
   assign negEdge = ~filtVec & filtDlyQ;
   assign intrEvt = intrEnQ & ((intrLvlQ & filtVec) |
                    (~intrLvlQ & ((intrPosQ & posEdge) | (intrNegQ & negEdge))));
   assign w1c     = (wrOk && regSel == REG_INTR_STAT) ? wdata : '0;

   always_comb begin
      dataOutD  = dataOutQ;
      oeD       = oeQ;
      intrEnD   = intrEnQ;
      intrPosD  = intrPosQ;
      intrNegD  = intrNegQ;
      intrLvlD  = intrLvlQ;
      filtEnD   = filtEnQ;
      filtCntD  = filtCntQ;
      intrStatD = (intrStatQ & ~w1c) | intrEvt;
      if (wrOk) begin
         case (regSel)
            REG_DATA_OUT: dataOutD = wdata;
            REG_OUT_SET:  dataOutD = dataOutQ | wdata;
            REG_OUT_CLR:  dataOutD = dataOutQ & ~wdata;
            REG_OUT_TGL:  dataOutD = dataOutQ ^ wdata;
            REG_OE:       oeD      = wdata;
            REG_INTR_EN:  intrEnD  = wdata;
            REG_INTR_POS: intrPosD = wdata;
            REG_INTR_NEG: intrNegD = wdata;
            REG_INTR_LVL: intrLvlD = wdata;
            REG_FILT_EN:  filtEnD  = wdata;
            REG_FILT_CNT: filtCntD = PWDATA[FILT_W-1:0];
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dataOutQ  <= '0;
         oeQ       <= '0;
         intrEnQ   <= '0;
         intrPosQ  <= '0;
         intrNegQ  <= '0;
         intrLvlQ  <= '0;
         intrStatQ <= '0;
         filtEnQ   <= '0;
         filtCntQ  <= '0;
         filtDlyQ  <= '0;
      end else begin
         dataOutQ  <= dataOutD;
         oeQ       <= oeD;
         intrEnQ   <= intrEnD;
         intrPosQ  <= intrPosD;
         intrNegQ  <= intrNegD;
         intrLvlQ  <= intrLvlD;
         intrStatQ <= intrStatD;
         filtEnQ   <= filtEnD;
         filtCntQ  <= filtCntD;
         filtDlyQ  <= filtVec;
      end
   end

   assign gpio_out  = dataOutQ;
   assign gpio_oe   = oeQ;
   assign interrupt = |intrStatQ;

endmodule

// File: doc/gpio_v2.md
GPIO_V2 -- requirements
Module: gpio_v2

Interface
REQ-001 SHALL have parameter NUM_PINS, default 32, number of GPIO pins (legal range 1..32).
REQ-002 SHALL have parameter FILT_W, default 4, width of per-pin glitch-filter threshold/counter.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port n_rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have APB slave ports: PSEL, PENABLE, PWRITE inputs of width 1; PADDR input of width 32; PWDATA input of width 32.
REQ-006 SHALL have APB slave outputs: PRDATA of width 32; PREADY of width 1; PSLVERR of width 1.
REQ-007 SHALL have port gpio_in, input, NUM_PINS, asynchronous pad inputs.
REQ-008 SHALL have port gpio_out, output, NUM_PINS, pad output data.
REQ-009 SHALL have port gpio_oe, output, NUM_PINS, pad output enables, 1 = drive.
REQ-010 SHALL have port interrupt, output, 1, OR of all INTR_STAT bits.

Function
REQ-011 SHALL use byte offsets PADDR[7:0]: 0x00 DATA_IN RO, 0x04 DATA_OUT RW, 0x08 OUT_SET WO, 0x0C OUT_CLR WO, 0x10 OUT_TGL WO, 0x14 OE RW, 0x18 INTR_EN RW, 0x1C INTR_POS RW, 0x20 INTR_NEG RW, 0x24 INTR_LVL RW, 0x28 INTR_STAT RW1C, 0x2C FILT_EN RW, 0x30 FILT_CNT RW, FILT_W bits.
REQ-012 SHALL tie PREADY to 1 (zero wait states); PRDATA SHALL be combinational in the access phase, with unused upper bits 0.
REQ-013 SHALL assert PSLVERR in the access phase for unmapped offsets, for writes to DATA_IN, and for reads of OUT_SET/OUT_CLR/OUT_TGL; such reads return 0 and such writes have no effect.
REQ-014 SHALL commit writes on the clk edge ending the access phase (PSEL&PENABLE&PWRITE).
REQ-015 SHALL apply OUT_SET/OUT_CLR/OUT_TGL as DATA_OUT|=, &=~, ^= PWDATA; bits written 0 are unchanged.
REQ-016 SHALL drive gpio_out=DATA_OUT and gpio_oe=OE directly from registers.
REQ-017 SHALL pass each pin through a 2-flop synchronizer, then a filter producing registered value filt.
REQ-018 For each filter with FILT_EN[i]=0, SHALL set filt[i] to sync[i] every cycle and hold the counter at 0.
REQ-019 For each filter with FILT_EN[i]=1: on mismatch with counter>=FILT_CNT, SHALL set filt<=sync and counter<=0; on mismatch otherwise, SHALL increment the counter (saturating); on match, SHALL set counter<=0.
REQ-020 SHALL reach DATA_IN, which reads filt, 3 clocks after a stable pin change with FILT_EN=0, and 3+FILT_CNT clocks after it with FILT_EN=1. FILT_CNT=0 SHALL equal the bypass timing.
REQ-021 SHALL apply new FILT_CNT or FILT_EN values to in-flight counters from the next cycle, with no counter reset.
REQ-022 SHALL define edge detection as pos=filt&~filt_d and neg=~filt&filt_d, with filt_d a register of filt.
REQ-023 SHALL form the event as INTR_EN & ((INTR_LVL & filt) | (~INTR_LVL & ((INTR_POS&pos)|(INTR_NEG&neg)))).
REQ-024 SHALL update INTR_STAT <= (INTR_STAT & ~w1c) | event, where w1c is PWDATA on an INTR_STAT write and 0 otherwise; a set SHALL win over a simultaneous clear.
REQ-025 SHALL re-set a level-mode bit on the cycle after a W1C while the pin remains high.
REQ-026 SHALL make interrupt combinational from INTR_STAT and SHALL NOT gate it again with INTR_EN.

Reset
REQ-027 SHALL clear all registers, synchronizers, filt, filt_d and counters to 0 on n_rst low; PRDATA SHALL be 0 and PSLVERR 0.
REQ-028 SHALL cause no edge event at reset release, because filt and filt_d are equal at 0.
REQ-029 SHALL abort an APB transfer in flight at reset, with no register change.

Structure
REQ-030 SHALL define register offset localparams and an enumerated register index in shared package gpio_v2_pkg.
REQ-031 SHALL place the synchronizer, filter counter and filt register in sub-module gpio_pin_filter, instantiated NUM_PINS times via generate.
REQ-032 SHALL keep the APB decode, the registers and the interrupt logic in gpio_v2 itself.

Verification
REQ-033 Bench SHALL check: write DATA_OUT=0x0000_00F0, then OUT_SET 0x1, OUT_CLR 0x10, OUT_TGL 0x3 -> readback 0x0000_00E2, gpio_out matches.
REQ-034 Bench SHALL check: FILT_EN[0]=1, FILT_CNT=5, 4-cycle glitch on pin0 -> DATA_IN[0] unchanged; 10-cycle pulse -> DATA_IN[0]=1 exactly 8 clocks after the pin change.
REQ-035 Bench SHALL check: INTR_EN[3]=1, INTR_POS[3]=1, pin3 rises with filter off -> interrupt=1 on the 4th clock edge; W1C 0x8 -> interrupt=0 next cycle.
REQ-036 Bench SHALL check: INTR_LVL[2]=1, pin2 held high, W1C 0x4 -> INTR_STAT[2] re-reads 1; drop pin2, then W1C -> stays 0.
REQ-037 Bench SHALL check: a neg-edge event on the same cycle as a W1C of that bit -> bit remains 1.
REQ-038 Bench SHALL check: read offset 0x40 -> PSLVERR=1, PRDATA=0; n_rst pulse mid-transfer -> all registers read 0, with no spurious interrupt.
